// File: rtl/divisor_sequencial_pkg.sv
// divisor_sequencial shared definitions:
// FSM encodings and divide-by-zero constants.
package divisor_sequencial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] DIV_ZERO_Q = 4'hF;
  localparam logic [1:0] CNT_MSB    = 2'd3;

endpackage

// File: rtl/estagiodivisao.sv
// One restoring-division step: shift in a dividend bit,
// try to subtract the divisor, restore on borrow.
module estagiodivisao (
  input  logic [3:0] resto_anterior,
  input  logic       d_bit,
  input  logic [3:0] b,
  output logic       q_bit,
  output logic [3:0] resto_novo
);

  logic [3:0] shifted;
  logic [3:0] diff;
  logic       borrow;

  assign shifted = {resto_anterior[2:0], d_bit};

  subtrator4x4 u_sub (
    .a      (shifted),
    .b      (b),
    .diff   (diff),
    .borrow (borrow)
  );

  // Top bit shifted out can only be 0 for 4-bit dividends.
  assign q_bit = resto_anterior[3] | ~borrow;

  muxdivisor4x4 u_mux (
    .sel (q_bit),
    .a   (diff),
    .b   (shifted),
    .y   (resto_novo)
  );

endmodule

// File: rtl/muxdivisor4x4.sv
// 4-bit 2:1 restore mux of the division stage:
// picks the difference when sel is high.
module muxdivisor4x4 (
  input  logic       sel,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/subtrator4x4.sv
// 4-bit subtractor with borrow out,
// used by the division stage.
module subtrator4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       borrow
);

  logic [4:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[3:0];
  assign borrow = full[4];

endmodule

// File: rtl/divisor_sequencial.sv
// Iterative 4-bit restoring divider: one stage
// reused over four cycles, start/busy/done handshake.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [3:0] r_reg;
  logic [3:0] q_reg;
  logic [1:0] cnt;
  logic       dz_reg;
  logic       accept;
  logic       d_bit;
  logic       q_bit;
  logic [3:0] r_new;

  assign accept = start && (state != ST_CALC);
  assign d_bit  = a_reg[cnt];

  estagiodivisao u_stage (
    .resto_anterior (r_reg),
    .d_bit          (d_bit),
    .b              (b_reg),
    .q_bit          (q_bit),
    .resto_novo     (r_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_nx = (B == 4'd0) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == 2'd0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start)
          state_nx = (B == 4'd0) ? ST_DONE : ST_CALC;
        else
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      q_reg  <= '0;
      cnt    <= '0;
      dz_reg <= 1'b0;
    end else if (accept) begin
      a_reg  <= A;
      b_reg  <= B;
      cnt    <= CNT_MSB;
      dz_reg <= (B == 4'd0);
      if (B == 4'd0) begin
        q_reg <= DIV_ZERO_Q;
        r_reg <= A;
      end else begin
        q_reg <= '0;
        r_reg <= '0;
      end
    end else if (state == ST_CALC) begin
      q_reg[cnt] <= q_bit;
      r_reg      <= r_new;
      if (cnt != 2'd0) cnt <= cnt - 2'd1;
    end
  end

  assign Q        = q_reg;
  assign R        = r_reg;
  assign div_zero = dz_reg;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed self-checking bench for divisor_sequencial:
// vector table plus hand-written multi-cycle sequences.
module tb_divisor_sequencial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  divisor_sequencial dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one division, then watch up to 8 cycles for done.
  task automatic run_div(input vec_t v);
    int lat;
    int nbusy;
    int both;
    lat   = 0;
    nbusy = 0;
    both  = 0;
    @(negedge clk);
    A = v.a;
    B = v.b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) both++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("latency %0d/%0d", v.a, v.b), lat, v.lat);
    chk($sformatf("busy_cycles %0d/%0d", v.a, v.b), nbusy, v.lat - 1);
    chk($sformatf("busy_and_done %0d/%0d", v.a, v.b), both, 0);
    chk($sformatf("Q %0d/%0d", v.a, v.b), int'(Q), int'(v.q));
    chk($sformatf("R %0d/%0d", v.a, v.b), int'(R), int'(v.r));
    chk($sformatf("div_zero %0d/%0d", v.a, v.b), int'(div_zero), int'(v.dz));
  endtask

  initial begin
    int ndone;
    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5};
    vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    vecs[4] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0, 5};
    vecs[5] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1};
    vecs[6] = '{4'd10, 4'd3,  4'd3,  4'd1, 1'b0, 5};
    vecs[7] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};

    rst = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    #12;
    chk("reset Q", int'(Q), 0);
    chk("reset R", int'(R), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset div_zero", int'(div_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i]);

    // Divide by zero: result and flag held after done.
    run_div(vecs[5]);
    @(negedge clk);
    chk("dz hold flag", int'(div_zero), 1);
    chk("dz hold Q", int'(Q), 15);
    chk("dz hold done", int'(done), 0);
    run_div(vecs[0]);

    // Start during CALC is ignored.
    @(negedge clk);
    A = 4'd13;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 2) begin
        A = 4'd5;
        B = 4'd1;
        start = 1'b1;
      end
      if (n == 3) start = 1'b0;
      if (done) begin
        ndone++;
        chk("ignored start done cycle", n, 5);
        chk("ignored start Q", int'(Q), 4);
        chk("ignored start R", int'(R), 1);
      end
    end
    chk("ignored start done count", ndone, 1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    A = 4'd13;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre-abort busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort Q", int'(Q), 0);
    chk("abort R", int'(R), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort no done", ndone, 0);
    run_div('{4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 5});

    // Start held high: back-to-back divisions.
    @(negedge clk);
    A = 4'd10;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 4'd8;
    B = 4'd2;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) ndone++;
      if (n == 5) begin
        chk("b2b first done", int'(done), 1);
        chk("b2b first Q", int'(Q), 3);
        chk("b2b first R", int'(R), 1);
      end
      if (n == 6) chk("b2b retrigger busy", int'(busy), 1);
      if (n == 10) begin
        chk("b2b second done", int'(done), 1);
        chk("b2b second Q", int'(Q), 4);
        chk("b2b second R", int'(R), 0);
        start = 1'b0;
      end
    end
    chk("b2b done count", ndone, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
